// File: rtl/dequantizer_pkg.sv
// Shared JPEG constants: block geometry, luminance quantization table and
// a saturation helper used by both the quantizer and the dequantizer.
package dequantizer_pkg;

    localparam int BLOCK_SIZE = 64;
    localparam int IDX_W      = 6;

    // Raster order (row*8 + col), identical to the encoder's table.
    localparam logic [7:0] QUANT_TABLE [BLOCK_SIZE] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    typedef struct packed {
        logic last;
        logic err;
    } tag_t;

    // Clamp v to the signed range of a w-bit integer (w < 32).
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                    input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/quant_matrix_rom.sv
// Combinational lookup of the 64-entry luminance quantization table.
module quant_matrix_rom
    import dequantizer_pkg::*;
(
    input  logic [IDX_W-1:0] addr,
    output logic [7:0]       q_val
);

    assign q_val = QUANT_TABLE[addr];

endmodule

// File: rtl/dequantizer.sv
// Two-stage streaming dequantizer: table lookup + framing check, then
// multiply and saturate, with valid/ready backpressure on both sides.
module dequantizer
    import dequantizer_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                   out_last,
    output logic                   err
);

    localparam int PW = IN_W + 9;
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(BLOCK_SIZE - 1);

    logic [IDX_W-1:0]        idx;
    logic [7:0]              q_rom;
    logic                    s1_valid;
    logic signed [IN_W-1:0]  s1_coef;
    logic [7:0]              s1_q;
    tag_t                    s1_tag;
    logic                    s2_valid;
    logic                    s2_load;
    logic                    accept;
    logic                    idx_end;
    logic signed [PW-1:0]    coef_x;
    logic signed [PW-1:0]    q_x;
    logic signed [PW-1:0]    prod;
    logic signed [OUT_W-1:0] sat_val;

    quant_matrix_rom u_rom (
        .addr  (idx),
        .q_val (q_rom)
    );

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign accept    = in_valid && in_ready;
    assign idx_end   = (idx == IDX_END);
    assign out_valid = s2_valid;

    // q_val is unsigned: zero-extend it before the signed multiply.
    assign coef_x  = PW'(s1_coef);
    assign q_x     = $signed(PW'({1'b0, s1_q}));
    assign prod    = coef_x * q_x;
    assign sat_val = OUT_W'(saturate(32'(prod), OUT_W));

    // Stage 1: index tracking, table lookup and framing check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            s1_valid <= 1'b0;
            s1_coef  <= '0;
            s1_q     <= '0;
            s1_tag   <= '0;
        end else begin
            if (accept) begin
                // An early in_last resynchronises the next input to index 0.
                if (in_last && !idx_end) idx <= '0;
                else                     idx <= idx + 1'b1;
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_coef    <= in_data;
                    s1_q       <= q_rom;
                    s1_tag.last <= idx_end || in_last;
                    s1_tag.err  <= idx_end != in_last;
                end
            end
        end
    end

    // Stage 2: registered outputs, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            err      <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            out_last <= s1_valid && s1_tag.last;
            err      <= s1_valid && s1_tag.err;
            if (s1_valid) out_data <= sat_val;
        end
    end

endmodule

// File: doc/dequantizer.md
# dequantizer

Streaming JPEG dequantizer for the decoder path. It accepts quantized DCT coefficients in raster order (index = row*8 + col), one 64-coefficient block after another. Each coefficient is multiplied by the luminance quantization value for its index, and the result is saturated and emitted to the IDCT. It is the decode-side counterpart of the encoder's quantizer and reads the same 64-entry quantization table.

## Interface
Parameters:
- IN_W, default 12: signed input coefficient width.
- OUT_W, default 16: signed output coefficient width; must satisfy OUT_W ≥ IN_W.

Ports (clock and reset first):
- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: input coefficient present.
- in_ready, output, 1: block can accept an input this cycle.
- in_data, input, IN_W: signed quantized coefficient.
- in_last, input, 1: upstream marks the coefficient at index 63.
- out_valid, output, 1: output coefficient present.
- out_ready, input, 1: downstream accepts the output.
- out_data, output, OUT_W: signed dequantized coefficient.
- out_last, output, 1: the output is coefficient 63 of its block.
- err, output, 1: one-cycle pulse on a block-framing mismatch.

## Operation
- An input is accepted when in_valid && in_ready. An output transfers when out_valid && out_ready.
- Index counter idx (6 bits):
  - Reset value is 0.
  - Increments on each accepted input and wraps from 63 to 0.
  - Its value at acceptance addresses the quantization table (16, 11, 10, 16, … 99).
- Stage 1 registers: the coefficient, q_val = table[idx], last1 = (idx == 63), and err1.
- Stage 2 registers:
  - product = signed(in_data) × unsigned(q_val), computed at IN_W+9 bits.
  - The product is saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - The result drives out_data; last1 drives out_last.
- Framing check, applied at acceptance:
  - in_last=1 with idx≠63: err1=1, and idx is forced to 0 for the next input (resync). The coefficient still passes through with out_last=1.
  - in_last=0 with idx==63: err1=1, idx wraps normally, and out_last=1.
  - In both cases, err pulses for one cycle when that coefficient transfers at the output.
- Backpressure:
  - Each stage loads when it is empty or when its contents advance in the same cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - There are no bubbles under continuous flow, and no data is ever dropped or duplicated.

## Timing
- Latency is 2 cycles, from input acceptance to out_valid, when there is no backpressure.
- Throughput is 1 coefficient per cycle; a full block takes 64 cycles.
- Reset values: out_valid=0, out_data=0, out_last=0, err=0, idx=0, both stage valids 0. in_ready reads 1 once rst_n is high.
- When rst_n is asserted mid-block, the pipeline empties immediately and idx returns to 0. The first input after reset is treated as index 0.
- While out_valid=1 && out_ready=0, out_data, out_last and err hold stable. This is a required handshake rule.
- A simultaneous input accept and output transfer with both stages full is legal; the pipeline shifts by one entry.

## Structure
- The shared JPEG package holds:
  - BLOCK_SIZE=64 and IDX_W=6;
  - the quantization table as a 64-entry constant, shared with the encoder;
  - a saturate-to-width function.
- The block contains one sub-module: the existing quantization table ROM (quant_matrix_rom, 6-bit addr, 8-bit q_val). It is addressed combinationally by idx.

## Test plan
- Reset, then stream index 0 = −5 and index 1 = −5 back-to-back.
  - Required response: out_data −80 (q=16), then −55 (q=11), at 2-cycle latency.
- Index 0 = 2047 and index 0 (next block) = −2048.
  - Required response: 32752 and −32768, with no saturation.
- Index 37 = 2047 (q=109).
  - Required response: out_data saturates to 32767.
  - Index 37 = −2048 instead yields −32768.
- Two full blocks with in_last on index 63 and random out_ready stalls.
  - Required response: 128 outputs in order, matching the reference model.
  - out_last on outputs 63 and 127, err never asserted, outputs held stable during every stall.
- in_last at index 10: err pulses with that output, out_last=1, and the next input uses q=16 (index 0). A separate case omits in_last at index 63: err pulses and the counter still wraps.
- Assert rst_n low after 20 inputs with the pipeline full.
  - Required response: outputs clear to zero immediately; after release, the first input uses q=16.
